// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz answer timer.
// State encoding, 7-segment glyphs and digit codes.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPED,
    EXPIRED
  } state_t;

  localparam int DEFAULT_ANSWER_SEC = 30;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp kept off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] CODE_P     = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern.
// code: 0-9 digits, 10 = "P", anything else blank; seg: {dp,g,f,e,d,c,b,a}.
module seg7_decode
  import quiz_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      CODE_P:  seg = SEG_P;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/answer_timer.sv
// Answer-window countdown behind the buzzer selector, with 4-digit display.
// In: CLK, RST, Timer_Start, Player_Number, Judge_Stop. Out: Sec_Left, Busy,
// Time_Up, Alarm, Seg_Out (active-low segs), Dig_Sel (active-low, bit3 left).
module answer_timer
  import quiz_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ANSWER_SEC   = DEFAULT_ANSWER_SEC,
  parameter int SCAN_DIV     = 50_000,
  parameter int ALARM_CYCLES = 25_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Timer_Start,
  input  logic [3:0] Player_Number,
  input  logic       Judge_Stop,
  output logic [5:0] Sec_Left,
  output logic       Busy,
  output logic       Time_Up,
  output logic       Alarm,
  output logic [7:0] Seg_Out,
  output logic [3:0] Dig_Sel
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(ALARM_CYCLES + 1);

  localparam logic [3:0] TENS0 = 4'(ANSWER_SEC / 10);
  localparam logic [3:0] ONES0 = 4'(ANSWER_SEC % 10);

  state_t state, state_n;

  logic          ts_q;
  logic          rise;
  logic          tick;
  logic [3:0]    tens, tens_n;
  logic [3:0]    ones, ones_n;
  logic [3:0]    player, player_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    code;
  logic [7:0]    seg_n;

  assign rise    = Timer_Start & ~ts_q;
  assign tick    = (presc == PW'(CLK_HZ - 1));
  assign Busy    = (state != IDLE);
  assign Time_Up = (state == EXPIRED);

  always_comb begin
    state_n  = state;
    tens_n   = tens;
    ones_n   = ones;
    player_n = player;
    presc_n  = presc;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n  = RUN;
          player_n = Player_Number;
          tens_n   = TENS0;
          ones_n   = ONES0;
          presc_n  = '0;
        end
      end
      RUN: begin
        if (!Timer_Start) begin
          state_n  = IDLE;
          tens_n   = '0;
          ones_n   = '0;
          player_n = '0;
          presc_n  = '0;
        end else if (Judge_Stop) begin
          state_n = STOPPED;
        end else if (tick) begin
          presc_n = '0;
          if (tens == 4'd0 && ones == 4'd1) begin
            ones_n  = 4'd0;
            state_n = EXPIRED;
          end else if (ones == 4'd0) begin
            ones_n = 4'd9;
            tens_n = tens - 4'd1;
          end else begin
            ones_n = ones - 4'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: begin
        if (!Timer_Start) begin
          state_n  = IDLE;
          tens_n   = '0;
          ones_n   = '0;
          player_n = '0;
          presc_n  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ts_q     <= 1'b0;
      tens     <= '0;
      ones     <= '0;
      player   <= '0;
      presc    <= '0;
      Sec_Left <= '0;
      Alarm    <= 1'b0;
      acnt     <= '0;
    end else begin
      state    <= state_n;
      ts_q     <= Timer_Start;
      tens     <= tens_n;
      ones     <= ones_n;
      player   <= player_n;
      presc    <= presc_n;
      Sec_Left <= 6'(tens_n) * 6'd10 + 6'(ones_n);
      if (state_n == IDLE) begin
        Alarm <= 1'b0;
        acnt  <= '0;
      end else if (state == RUN && state_n == EXPIRED) begin
        Alarm <= 1'b1;
        acnt  <= '0;
      end else if (Alarm) begin
        if (acnt == AW'(ALARM_CYCLES - 1)) begin
          Alarm <= 1'b0;
        end else begin
          acnt <= acnt + AW'(1);
        end
      end
    end
  end

  // Display content follows the next-state values so the digits
  // switch on the same edge as the state they show.
  always_comb begin
    code = CODE_BLANK;
    if (state_n != IDLE) begin
      unique case (idx)
        2'd3: code = CODE_P;
        2'd2: code = (player_n > 4'd9) ? CODE_BLANK : player_n;
        2'd1: code = (tens_n == 4'd0) ? CODE_BLANK : tens_n;
        default: code = ones_n;
      endcase
    end
  end

  seg7_decode u_dec (
    .code (code),
    .seg  (seg_n)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      idx      <= '0;
      Seg_Out  <= SEG_BLANK;
      Dig_Sel  <= 4'b1110;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      Seg_Out <= seg_n;
      Dig_Sel <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: doc/answer_timer.md
# answer_timer

Countdown stage directly downstream of the quiz buzzer selector. Starts when the selector raises its Timer_Start level, latches the winning Player_Number and counts the answer window down in whole seconds. Shows "P", the player digit and the two-digit remaining time on a 4-digit multiplexed 7-segment display. Flags expiry with a level plus a fixed-length alarm pulse, and supports a judge stop that freezes the count.

## Interface
- CLK_HZ, 50_000_000, clock cycles per second tick (≥2)
- ANSWER_SEC, 30, answer window in seconds, legal 1..59
- SCAN_DIV, 50_000, clock cycles per displayed digit (≥2)
- ALARM_CYCLES, 25_000_000, Alarm pulse length in cycles (≥1)

- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- Timer_Start  in  1  level from selector; high while a player holds the floor
- Player_Number  in  4  winning player from selector (1..4), sampled on Timer_Start rise
- Judge_Stop  in  1  synchronous, debounced, active-high; freezes countdown
- Sec_Left  out  6  remaining seconds, binary
- Busy  out  1  high in RUN, STOPPED or EXPIRED
- Time_Up  out  1  level, high in EXPIRED
- Alarm  out  1  high for ALARM_CYCLES after expiry
- Seg_Out  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- Dig_Sel  out  4  active-low digit enables, bit 3 = leftmost

## Operation
- Reset values: state IDLE, Sec_Left 0, Busy 0, Time_Up 0, Alarm 0, Seg_Out 8'hFF, Dig_Sel 4'b1110. All counters and the player latch are cleared.
- Timer_Start is registered once (ts_q). A rise means Timer_Start=1 and ts_q=0.
- States and transitions:
  - IDLE: on rise, latch Player_Number, load tens/ones BCD from ANSWER_SEC, clear the prescaler -> RUN.
  - RUN: the prescaler counts 0..CLK_HZ-1, and wrap is the tick. On a tick with remaining time >1, decrement the BCD pair (ones 0 -> 9 with tens-1). On a tick with remaining time ==1, go to 00 -> EXPIRED.
  - RUN with Judge_Stop=1 -> STOPPED, count frozen, prescaler held.
  - STOPPED and EXPIRED: hold until Timer_Start falls.
  - Any non-IDLE state with Timer_Start=0 -> IDLE, clearing the BCD pair, the player latch and Alarm.
- Precedence within one cycle: Timer_Start=0 > Judge_Stop > tick. A stop coinciding with a tick does not decrement.
- Judge_Stop is ignored in IDLE, STOPPED and EXPIRED.
- A second Timer_Start rise while not in IDLE is impossible by protocol and is ignored.
- Sec_Left = tens*10 + ones, registered alongside the BCD pair.
- Alarm: set on entry to EXPIRED, and a counter clears it after ALARM_CYCLES cycles. Alarm is also cleared on return to IDLE.
- Display scanner runs in all states: a counter of SCAN_DIV cycles advances the digit index 0→1→2→3→0. Dig_Sel is the active-low one-hot of the index.
  - Digit 3 shows the glyph "P".
  - Digit 2 shows the player (blank if >9).
  - Digit 1 shows tens, blanked when 0.
  - Digit 0 shows ones.
  - In IDLE all digits show blank (8'hFF).
  - dp is always off.

## Timing
- Rise sampled at edge N gives Busy=1 and Sec_Left=ANSWER_SEC after edge N+1.
- The first decrement comes CLK_HZ cycles after RUN entry. Time_Up rises ANSWER_SEC*CLK_HZ cycles after RUN entry, in the same cycle Sec_Left reaches 0.
- Alarm rises with Time_Up and is high exactly ALARM_CYCLES cycles.
- Timer_Start fall at edge N gives IDLE and all outputs at their reset values (except the scanner) after N+1.
- Seg_Out and Dig_Sel are registered and change together, with one cycle of latency from the digit index.
- Reset asserted mid-count returns all outputs to their reset values asynchronously. No tick is pending after release.

## Structure
- Package quiz_pkg holds:
  - state enum {IDLE, RUN, STOPPED, EXPIRED}
  - segment glyph constants: digits 0–9, P, BLANK (active-low)
  - default ANSWER_SEC
- Sub-module seg7_decode: combinational 4-bit code (0–9, 10=P, 15=blank) to 8-bit active-low segments. It is instantiated once after the digit multiplexer.

## Test plan
Bench parameters: CLK_HZ=10, ANSWER_SEC=3, SCAN_DIV=4, ALARM_CYCLES=5.
- Reset, then idle 50 cycles -> Busy=0, Sec_Left=0, Seg_Out=8'hFF, Dig_Sel rotates 1110→1101→1011→0111 every 4 cycles.
- Raise Timer_Start with Player_Number=3 -> Sec_Left 3 after 1 cycle, 2 after 10 more, 1 after 20, 0 with Time_Up=1 after 30, Alarm high exactly 5 cycles.
- In RUN, check the display -> digit3=P, digit2=3, digit1 blank, digit0 = current ones value.
- Pulse Judge_Stop at Sec_Left=2 on a tick cycle -> Sec_Left stays 2 for 100 cycles, Time_Up stays 0.
- Drop Timer_Start during EXPIRED with Alarm high -> next cycle Alarm=0, Time_Up=0, Busy=0, Seg_Out blank. A new rise restarts at 3.
- ANSWER_SEC=12, assert RST at Sec_Left=10 -> immediate reset values. After release, no countdown without a new rise.
